// File: rtl/equilibrium_maxxing_pkg.sv
// Shared definitions for the Equilibrium Maxxing round controller and datapath:
// state encoding, level ceiling, default timing constants and width helpers.
package equilibrium_maxxing_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PREPARA = 3'd1,
        GERA    = 3'd2,
        AGUARDA = 3'd3,
        AVALIA  = 3'd4,
        FADE    = 3'd5,
        FIM     = 3'd6
    } estado_t;

    localparam int NIVEL_MAX = 3;

    localparam int ACERTOS_POR_NIVEL_DEF = 5;
    localparam int VIDAS_INICIAIS_DEF    = 3;
    localparam int TIMEOUT_CICLOS_DEF    = 50_000_000;  // 1 s at 50 MHz
    localparam int FADE_CICLOS_DEF       = 25_000_000;

    localparam int NIVEL_W   = 2;
    localparam int VIDAS_W   = 2;
    localparam int ACERTOS_W = 10;
    localparam int ESTADO_W  = 3;

    // Bits needed to hold values 0..valor_max, never fewer than one.
    function automatic int contador_largura(input int valor_max);
        return (valor_max < 1) ? 1 : $clog2(valor_max + 1);
    endfunction

endpackage

// File: rtl/equilibrium_maxxing_rodada_ctrl_if.sv
// Control/event bundle between the round controller and the datapath.
// master: controller side (drives strobes and status); slave: datapath side.
interface equilibrium_maxxing_rodada_ctrl_if;
    import equilibrium_maxxing_pkg::*;

    logic                 iniciar;
    logic                 ganhou_ponto;
    logic                 perdeu_ponto;
    logic                 gerar_nova_jogada;
    logic                 conta_nivel;
    logic                 reset_nivel;
    logic                 fade_trigger;
    logic [NIVEL_W-1:0]   nivel_dificuldade;
    logic [VIDAS_W-1:0]   vidas;
    logic [ACERTOS_W-1:0] acertos;
    logic                 fim_jogo;
    logic [ESTADO_W-1:0]  db_estado;

    modport master (
        input  iniciar, ganhou_ponto, perdeu_ponto,
        output gerar_nova_jogada, conta_nivel, reset_nivel, fade_trigger,
               nivel_dificuldade, vidas, acertos, fim_jogo, db_estado
    );

    modport slave (
        output iniciar, ganhou_ponto, perdeu_ponto,
        input  gerar_nova_jogada, conta_nivel, reset_nivel, fade_trigger,
               nivel_dificuldade, vidas, acertos, fim_jogo, db_estado
    );

endinterface

// File: rtl/equilibrium_maxxing_temporizador.sv
// Loadable down-counter: load takes priority, enable counts down to zero and
// holds there; done is high whenever the count is zero.
module equilibrium_maxxing_temporizador #(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic [LARGURA-1:0] load_value,
    input  logic               enable,
    output logic               done
);

    logic [LARGURA-1:0] contagem;

    // Count register: reload or step toward zero.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= '0;
        end else if (load) begin
            contagem <= load_value;
        end else if (enable && (contagem != '0)) begin
            contagem <= contagem - LARGURA'(1);
        end
    end

    assign done = (contagem == '0);

endmodule

// File: rtl/equilibrium_maxxing_rodada_ctrl.sv
// Round scheduler: starts a game, requests plays, waits for a point event or
// timeout, scores hits/misses, advances the level and runs the fade between
// rounds. All strobes are registered one-cycle pulses.
module equilibrium_maxxing_rodada_ctrl
    import equilibrium_maxxing_pkg::*;
#(
    parameter int ACERTOS_POR_NIVEL = ACERTOS_POR_NIVEL_DEF,
    parameter int VIDAS_INICIAIS    = VIDAS_INICIAIS_DEF,
    parameter int TIMEOUT_CICLOS    = TIMEOUT_CICLOS_DEF,
    parameter int FADE_CICLOS       = FADE_CICLOS_DEF
) (
    input  logic                               clock,
    input  logic                               reset,
    equilibrium_maxxing_rodada_ctrl_if.master  bus
);

    localparam int TO_W = contador_largura(TIMEOUT_CICLOS - 1);
    localparam int FD_W = contador_largura(FADE_CICLOS - 1);
    localparam int HC_W = contador_largura(ACERTOS_POR_NIVEL - 1);

    localparam logic [TO_W-1:0]    TO_CARGA    = TO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [FD_W-1:0]    FD_CARGA    = FD_W'(FADE_CICLOS - 1);
    localparam logic [HC_W-1:0]    HC_ULTIMO   = HC_W'(ACERTOS_POR_NIVEL - 1);
    localparam logic [VIDAS_W-1:0] VIDAS_INIT  = VIDAS_W'(VIDAS_INICIAIS);
    localparam logic [NIVEL_W-1:0] NIVEL_TOPO  = NIVEL_W'(NIVEL_MAX);

    estado_t              estado;
    logic                 acerto_r;       // outcome latched on AGUARDA exit
    logic [HC_W-1:0]      acertos_nivel;  // hits since the last level step
    logic [NIVEL_W-1:0]   nivel;
    logic [VIDAS_W-1:0]   vidas;
    logic [ACERTOS_W-1:0] acertos;
    logic                 gerar_r, conta_r, reset_nivel_r, fade_r, fim_r;

    logic to_load, to_enable, to_done;
    logic fd_load, fd_enable, fd_done;
    logic sobe_nivel;

    // Timeout window: armed in GERA (and PREPARA), runs only while AGUARDA.
    assign to_load   = (estado == GERA) || (estado == PREPARA);
    assign to_enable = (estado == AGUARDA);
    // Fade window: armed in AVALIA, runs while FADE.
    assign fd_load   = (estado == AVALIA);
    assign fd_enable = (estado == FADE);

    // A hit now completes the level quota and the level is not yet saturated.
    assign sobe_nivel = (acertos_nivel == HC_ULTIMO) && (nivel < NIVEL_TOPO);

    equilibrium_maxxing_temporizador #(.LARGURA(TO_W)) u_timeout (
        .clock      (clock),
        .reset      (reset),
        .load       (to_load),
        .load_value (TO_CARGA),
        .enable     (to_enable),
        .done       (to_done)
    );

    equilibrium_maxxing_temporizador #(.LARGURA(FD_W)) u_fade (
        .clock      (clock),
        .reset      (reset),
        .load       (fd_load),
        .load_value (FD_CARGA),
        .enable     (fd_enable),
        .done       (fd_done)
    );

    // Round FSM; each pulse is set on the edge entering the state it marks.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            acerto_r      <= 1'b0;
            acertos_nivel <= '0;
            nivel         <= '0;
            vidas         <= VIDAS_INIT;
            acertos       <= '0;
            gerar_r       <= 1'b0;
            conta_r       <= 1'b0;
            reset_nivel_r <= 1'b0;
            fade_r        <= 1'b0;
            fim_r         <= 1'b0;
        end else begin
            gerar_r       <= 1'b0;
            conta_r       <= 1'b0;
            reset_nivel_r <= 1'b0;
            fade_r        <= 1'b0;

            unique case (estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        estado        <= PREPARA;
                        reset_nivel_r <= 1'b1;
                    end
                end
                PREPARA: begin
                    nivel         <= '0;
                    acertos       <= '0;
                    acertos_nivel <= '0;
                    vidas         <= VIDAS_INIT;
                    estado        <= GERA;
                    gerar_r       <= 1'b1;
                end
                GERA: begin
                    estado <= AGUARDA;
                end
                AGUARDA: begin
                    // Miss wins over a simultaneous hit; a hit on the last
                    // timeout cycle still counts as a hit.
                    if (bus.perdeu_ponto) begin
                        acerto_r <= 1'b0;
                        estado   <= AVALIA;
                    end else if (bus.ganhou_ponto) begin
                        acerto_r <= 1'b1;
                        conta_r  <= sobe_nivel;
                        estado   <= AVALIA;
                    end else if (to_done) begin
                        acerto_r <= 1'b0;
                        estado   <= AVALIA;
                    end
                end
                AVALIA: begin
                    if (acerto_r) begin
                        if (acertos != '1) acertos <= acertos + ACERTOS_W'(1);
                        if (acertos_nivel == HC_ULTIMO) begin
                            acertos_nivel <= '0;
                            if (conta_r) nivel <= nivel + NIVEL_W'(1);
                        end else begin
                            acertos_nivel <= acertos_nivel + HC_W'(1);
                        end
                        estado <= FADE;
                        fade_r <= 1'b1;
                    end else begin
                        if (vidas != '0) vidas <= vidas - VIDAS_W'(1);
                        if (vidas <= VIDAS_W'(1)) begin
                            estado <= FIM;
                            fim_r  <= 1'b1;
                        end else begin
                            estado <= FADE;
                            fade_r <= 1'b1;
                        end
                    end
                end
                FADE: begin
                    if (fd_done) begin
                        estado  <= GERA;
                        gerar_r <= 1'b1;
                    end
                end
                FIM: begin
                    if (bus.iniciar) begin
                        estado        <= PREPARA;
                        fim_r         <= 1'b0;
                        reset_nivel_r <= 1'b1;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.gerar_nova_jogada = gerar_r;
    assign bus.conta_nivel       = conta_r;
    assign bus.reset_nivel       = reset_nivel_r;
    assign bus.fade_trigger      = fade_r;
    assign bus.nivel_dificuldade = nivel;
    assign bus.vidas             = vidas;
    assign bus.acertos           = acertos;
    assign bus.fim_jogo          = fim_r;
    assign bus.db_estado         = estado;

endmodule

// File: tb/tb_equilibrium_maxxing_rodada_ctrl.sv
// Scoreboard bench for the round controller: the driver plays rounds with
// random outcomes, a game-level model predicts the score after each round,
// and a monitor compares whenever a round ends (fade_trigger or game over).
module tb_equilibrium_maxxing_rodada_ctrl;
    import equilibrium_maxxing_pkg::*;

    localparam int APN = 2;
    localparam int VI  = 2;
    localparam int TO  = 20;
    localparam int FC  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    equilibrium_maxxing_rodada_ctrl_if bus ();

    equilibrium_maxxing_rodada_ctrl #(
        .ACERTOS_POR_NIVEL (APN),
        .VIDAS_INICIAIS    (VI),
        .TIMEOUT_CICLOS    (TO),
        .FADE_CICLOS       (FC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int acertos;
        int vidas;
        int nivel;
        int conta;
        int fim;
    } esperado_t;

    esperado_t fila[$];
    esperado_t e_mon;
    int  n_vec = 0;
    int  n_err = 0;
    int  conta_total  = 0;
    int  conta_rodada = 0;
    int  pulsos;
    logic fim_prev = 1'b0;

    // Game-level reference model
    int m_acertos, m_vidas, m_nivel, m_hits_nivel, m_conta_total;

    task automatic check(input string nome, input int atual, input int esperado);
        n_vec++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic int pulsos_agora();
        return int'(bus.gerar_nova_jogada) + int'(bus.conta_nivel) +
               int'(bus.reset_nivel) + int'(bus.fade_trigger);
    endfunction

    // Monitor: exclusivity of strobes, and score check at each round end.
    always @(negedge clock) begin
        if (reset) begin
            conta_rodada = 0;
        end else begin
            pulsos = pulsos_agora();
            if (pulsos > 0) check("pulse_exclusive", int'(pulsos <= 1), 1);
            if (bus.conta_nivel) begin
                conta_rodada++;
                conta_total++;
            end
            if (bus.fade_trigger || (bus.fim_jogo && !fim_prev)) begin
                if (fila.size() == 0) begin
                    check("round_end_expected", fila.size(), 1);
                end else begin
                    e_mon = fila.pop_front();
                    check("acertos",     int'(bus.acertos),           e_mon.acertos);
                    check("vidas",       int'(bus.vidas),             e_mon.vidas);
                    check("nivel",       int'(bus.nivel_dificuldade), e_mon.nivel);
                    check("conta_pulses", conta_rodada,               e_mon.conta);
                    check("fim_jogo",    int'(bus.fim_jogo),          e_mon.fim);
                    conta_rodada = 0;
                end
            end
        end
        fim_prev = bus.fim_jogo;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic model_round(input bit hit, output esperado_t e);
        int conta = 0;
        if (hit) begin
            if (m_acertos < 1023) m_acertos++;
            m_hits_nivel++;
            if (m_hits_nivel == APN) begin
                m_hits_nivel = 0;
                if (m_nivel < NIVEL_MAX) begin
                    m_nivel++;
                    conta = 1;
                    m_conta_total++;
                end
            end
        end else begin
            m_vidas--;
        end
        e = '{acertos: m_acertos, vidas: m_vidas, nivel: m_nivel,
              conta: conta, fim: int'(m_vidas == 0)};
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_estado"},  int'(bus.db_estado), int'(OCIOSO));
        check({tag, "_vidas"},   int'(bus.vidas), VI);
        check({tag, "_nivel"},   int'(bus.nivel_dificuldade), 0);
        check({tag, "_acertos"}, int'(bus.acertos), 0);
        check({tag, "_fim"},     int'(bus.fim_jogo), 0);
        check({tag, "_pulses"},  pulsos_agora(), 0);
    endtask

    task automatic quiet(input string tag, input int n);
        int cnt = 0;
        repeat (n) begin
            tick();
            cnt += pulsos_agora();
        end
        check({tag, "_no_pulse"}, cnt, 0);
        check({tag, "_idle"}, int'(bus.db_estado), int'(OCIOSO));
    endtask

    task automatic abort_with_reset(input string tag);
        reset = 1'b1;
        bus.iniciar = 1'b0;
        bus.ganhou_ponto = 1'b0;
        bus.perdeu_ponto = 1'b0;
        tick();
        check_reset_values(tag);
        fila.delete();
        reset = 1'b0;
        quiet(tag, 10);
    endtask

    // Ends on the negedge of the GERA cycle (gerar_nova_jogada high).
    task automatic start_game();
        m_acertos = 0; m_vidas = VI; m_nivel = 0; m_hits_nivel = 0; m_conta_total = 0;
        conta_total = 0;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        check("reset_nivel_latency", int'(bus.reset_nivel), 1);
        tick();
        check("gerar_latency", int'(bus.gerar_nova_jogada), 1);
        check("start_nivel", int'(bus.nivel_dificuldade), 0);
        check("start_vidas", int'(bus.vidas), VI);
        check("start_acertos", int'(bus.acertos), 0);
    endtask

    // acao: 0 hit, 1 miss, 2 hit+miss together, 3 timeout. d = AGUARDA cycle
    // of the event. Starts and (unless the game ends) finishes on a GERA negedge.
    task automatic play_round(input int acao, input int d);
        esperado_t e;
        int cnt;
        if (acao == 3) d = TO - 1;
        model_round(acao == 0, e);
        fila.push_back(e);
        repeat (d + 1) tick();
        if (acao == 0 || acao == 2) bus.ganhou_ponto = 1'b1;
        if (acao == 1 || acao == 2) bus.perdeu_ponto = 1'b1;
        tick();
        bus.ganhou_ponto = 1'b0;
        bus.perdeu_ponto = 1'b0;
        tick();
        if (e.fim != 0) begin
            check("fim_on_time", int'(bus.fim_jogo), 1);
            cnt = 0;
            repeat (20) begin
                tick();
                cnt += int'(bus.gerar_nova_jogada);
            end
            check("no_play_after_fim", cnt, 0);
            check("fim_holds", int'(bus.fim_jogo), 1);
        end else begin
            check("fade_on_time", int'(bus.fade_trigger), 1);
            // Stray events during FADE must be ignored.
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) bus.ganhou_ponto = 1'b1;
                else                           bus.perdeu_ponto = 1'b1;
            end
            tick();
            bus.ganhou_ponto = 1'b0;
            bus.perdeu_ponto = 1'b0;
            repeat (FC - 1) tick();
            check("gerar_after_fade", int'(bus.gerar_nova_jogada), 1);
        end
    endtask

    initial begin
        int rounds;
        int r;
        esperado_t e;
        bus.iniciar = 1'b0;
        bus.ganhou_ponto = 1'b0;
        bus.perdeu_ponto = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();
        check("idle_without_iniciar", int'(bus.db_estado), int'(OCIOSO));

        // Game 1: two hits (one on the last timeout cycle), simultaneous
        // hit+miss, then a timeout ends the game.
        start_game();
        play_round(0, 3);
        play_round(0, TO - 1);
        play_round(2, 0);
        play_round(3, 0);
        check("conta_total_g1", conta_total, m_conta_total);

        // Game 2 (restart from FIM): level saturation after 8 hits.
        start_game();
        repeat (8) play_round(0, $urandom_range(0, TO - 1));
        play_round(1, 5);
        play_round(3, 0);
        check("conta_total_sat", conta_total, 3);

        // Random games
        for (int gm = 0; gm < 6; gm++) begin
            start_game();
            rounds = 0;
            while (m_vidas > 0 && rounds < 40) begin
                r = $urandom_range(0, 9);
                if (r <= 5)      play_round(0, $urandom_range(0, TO - 1));
                else if (r == 6) play_round(1, $urandom_range(0, TO - 1));
                else if (r == 7) play_round(2, $urandom_range(0, TO - 1));
                else if (r == 8) play_round(3, 0);
                else             play_round(0, TO - 1);
                rounds++;
            end
            if (m_vidas > 0) abort_with_reset("rnd_abort");
            else             check("conta_total_rnd", conta_total, m_conta_total);
        end

        // Reset during FADE, with a stray hit inside FADE first.
        abort_with_reset("pre_fade");
        start_game();
        model_round(1'b1, e);
        fila.push_back(e);
        repeat (3) tick();
        bus.ganhou_ponto = 1'b1;
        tick();
        bus.ganhou_ponto = 1'b0;
        tick();
        check("fade_entry", int'(bus.fade_trigger), 1);
        bus.ganhou_ponto = 1'b1;
        tick();
        bus.ganhou_ponto = 1'b0;
        tick();
        check("fade_stray_hit_ignored", int'(bus.acertos), m_acertos);
        abort_with_reset("rst_fade");

        // Reset mid-AGUARDA.
        start_game();
        repeat (8) tick();
        check("in_aguarda", int'(bus.db_estado), int'(AGUARDA));
        abort_with_reset("rst_aguarda");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
